// File: rtl/silife_grid_sync_master.sv
// Sync strobe master for the inter-chip edge exchange: one WIDTH+1 pulse transfer per start, then drain.
// Optional drain watchdog enabled by defining SILIFE_SYNC_TIMEOUT_EN.
module silife_grid_sync_master #(
  parameter int WIDTH    = 32,
  parameter int EDGES    = 4,
  parameter int DIV_BITS = 4,
  parameter int SETTLE   = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [DIV_BITS-1:0] i_half_period,
  input  logic [EDGES-1:0]    i_edges_busy,
  output logic                o_sync_clk_syn,
  output logic                o_sync_active_syn,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int PW = $clog2(WIDTH + 2);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int CW = (DIV_BITS > SW) ? DIV_BITS : SW;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]       r_cnt;
  logic [DIV_BITS-1:0] r_hm1;
  logic [PW-1:0]       r_pulse;
  logic                r_sclk;
  logic                r_act;
  logic                r_busy;
  logic                r_done;

  logic [DIV_BITS-1:0] w_hm1_in;
  logic                w_lvl_end;
  logic                w_settled;
  logic                w_rx_idle;
  logic                w_last;
  logic                w_abort;
  logic                w_sclk_n;
  logic                w_act_n;
  logic                w_busy_n;
  logic                w_done_n;

  assign w_hm1_in  = (i_half_period < DIV_BITS'(3)) ?
                     DIV_BITS'(3) : i_half_period;
  assign w_lvl_end = (r_cnt == CW'(r_hm1));
  assign w_settled = (r_cnt == CW'(SETTLE - 1));
  assign w_rx_idle = (i_edges_busy == '0);
  assign w_last    = (r_pulse == PW'(WIDTH));

`ifdef SILIFE_SYNC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_wdog;
  logic          r_err;

  assign w_abort = w_settled && !w_rx_idle &&
                   (r_wdog == TW'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state != S_DRAIN)
        r_wdog <= '0;
      else if (w_settled && !w_rx_idle && !w_abort)
        r_wdog <= r_wdog + TW'(1);
      r_err <= (w_next == S_DONE) && w_abort;
    end
  end

  assign o_error = r_err;
`else
  assign w_abort = 1'b0;
  assign o_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sclk  <= 1'b1;
      r_act   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sclk  <= w_sclk_n;
      r_act   <= w_act_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next = S_SETUP;
      S_SETUP: if (w_lvl_end) w_next = S_LOW;
      S_LOW:   if (w_lvl_end)
                 w_next = w_last ? S_DRAIN : S_HIGH;
      S_HIGH:  if (w_lvl_end) w_next = S_LOW;
      S_DRAIN: if (w_settled && (w_rx_idle || w_abort))
                 w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sclk_n = (w_next != S_LOW);
    w_act_n  = (w_next == S_SETUP) || (w_next == S_LOW) ||
               (w_next == S_HIGH)  || (w_next == S_DRAIN);
    w_busy_n = (w_next != S_IDLE);
    w_done_n = (w_next == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_hm1   <= '0;
      r_pulse <= '0;
    end else begin
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state == S_DRAIN) begin
        if (!w_settled)
          r_cnt <= r_cnt + CW'(1);
      end else if (r_state != S_IDLE)
        r_cnt <= r_cnt + CW'(1);

      if (r_state == S_IDLE && i_start) begin
        r_hm1   <= w_hm1_in;
        r_pulse <= '0;
      end else if (r_state == S_LOW && w_lvl_end)
        r_pulse <= r_pulse + PW'(1);
    end
  end

  assign o_sync_clk_syn    = r_sclk;
  assign o_sync_active_syn = r_act;
  assign o_busy            = r_busy;
  assign o_done            = r_done;

endmodule

// File: tb/tb_silife_grid_sync_master.sv
// Scoreboard bench for silife_grid_sync_master (WIDTH=4, SETTLE=4, TIMEOUT=16).
module tb_silife_grid_sync_master;

  localparam int W  = 4;
  localparam int TO = 16;

  typedef struct {
    int         cyc;
    logic [4:0] o;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_start = 1'b0;
  logic [3:0] i_half_period = 4'd0;
  logic [3:0] i_edges_busy = 4'd0;
  logic       w_sclk;
  logic       w_act;
  logic       w_busy;
  logic       w_done;
  logic       w_err;
  logic [4:0] w_outs;

  ev_t        q[$];
  ev_t        ev;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         e0;
  logic [4:0] prev = 5'b10000;

  silife_grid_sync_master #(
    .WIDTH(W), .EDGES(4), .DIV_BITS(4),
    .SETTLE(4), .TIMEOUT(TO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_start          (i_start),
    .i_half_period    (i_half_period),
    .i_edges_busy     (i_edges_busy),
    .o_sync_clk_syn   (w_sclk),
    .o_sync_active_syn(w_act),
    .o_busy           (w_busy),
    .o_done           (w_done),
    .o_error          (w_err)
  );

  assign w_outs = {w_sclk, w_act, w_busy, w_done, w_err};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (w_outs !== prev) begin
      if (q.size() == 0)
        chk("sb_extra", {32'(cyc), 27'd0, w_outs}, '1);
      else begin
        ev = q.pop_front();
        chk("sb_evt", {32'(cyc), 27'd0, w_outs},
            {32'(ev.cyc), 27'd0, ev.o});
      end
      prev = w_outs;
    end
  end

  task automatic push_xfer(input int s, input int h,
                           input int d, input logic err);
    q.push_back('{s, 5'b11100});
    for (int k = 1; k <= W + 1; k++) begin
      q.push_back('{s + h + 2*h*(k-1), 5'b01100});
      q.push_back('{s + 2*h*k, 5'b11100});
    end
    q.push_back('{s + d, {4'b1011, err}});
    q.push_back('{s + d + 1, 5'b10000});
  endtask

  task automatic start_xfer(input logic [3:0] hp, input int d,
                            input logic err, output int s);
    int h;
    h = ((hp < 4'd3) ? 3 : int'(hp)) + 1;
    @(negedge clk);
    i_start = 1'b1;
    i_half_period = hp;
    s = cyc + 1;
    push_xfer(s, h, d, err);
    @(negedge clk);
    i_start = 1'b0;
    i_half_period = 4'($urandom);
  endtask

  task automatic at_edge(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d expected_finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_outs", 64'(w_outs), 64'(5'b10000));

    start_xfer(4'd3, 44, 1'b0, e0);
    at_edge(e0 + 47);

    start_xfer(4'd0, 44, 1'b0, e0);
    at_edge(e0 + 47);

    start_xfer(4'd7, 84, 1'b0, e0);
    at_edge(e0 + 87);

    i_edges_busy = 4'b0001;
    start_xfer(4'd3, 61, 1'b0, e0);
    at_edge(e0 + 10);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    at_edge(e0 + 50);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    at_edge(e0 + 61);
    i_edges_busy = 4'b0000;
    at_edge(e0 + 64);

    start_xfer(4'd3, 44, 1'b0, e0);
    at_edge(e0 + 44);
    i_start = 1'b1;
    i_half_period = 4'd4;
    push_xfer(e0 + 46, 5, 54, 1'b0);
    at_edge(e0 + 47);
    i_start = 1'b0;
    at_edge(e0 + 46 + 57);

    start_xfer(4'd3, 44, 1'b0, e0);
    at_edge(e0 + 23);
    reset = 1'b1;
    q.delete();
    q.push_back('{e0 + 23, 5'b10000});
    #1;
    chk("rst_mid_sclk", 64'(w_sclk), 64'(1));
    chk("rst_mid_act", 64'(w_act), 64'(0));
    chk("rst_mid_busy", 64'(w_busy), 64'(0));
    chk("rst_mid_done", 64'(w_done), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start_xfer(4'd3, 44, 1'b0, e0);
    at_edge(e0 + 47);

    i_edges_busy = 4'b0010;
`ifdef SILIFE_SYNC_TIMEOUT_EN
    start_xfer(4'd3, 44 + TO, 1'b1, e0);
    at_edge(e0 + 44 + TO + 3);
    i_edges_busy = 4'b0000;
`else
    start_xfer(4'd3, 101, 1'b0, e0);
    at_edge(e0 + 101);
    chk("no_err", 64'(w_err), 64'(0));
    i_edges_busy = 4'b0000;
    at_edge(e0 + 104);
`endif

    repeat (5) @(negedge clk);
    chk("sb_left", 64'(q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
